dram_arbiter: RTL and testbench
===============================

DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 Parameter AW, default 12, meaning data-memory address width (matches alpha field width).
REQ-002 Parameter DW, default 8, meaning data-memory word width.
REQ-003 Parameter STARVE_MAX, default 15, meaning maximum consecutive host grants while core_req is pending.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 core_req  input  1  core access request, held high until core_gnt.
REQ-007 core_we  input  1  core access type: 1 write, 0 read.
REQ-008 core_addr  input  AW  core address.
REQ-009 core_wdata  input  DW  core write data.
REQ-010 core_gnt  output  1  one-cycle pulse: core access issued to memory.
REQ-011 core_rdata  output  DW  core read data, valid only while core_rvalid is high.
REQ-012 core_rvalid  output  1  one-cycle pulse: core_rdata valid.
REQ-013 host_req, host_we, host_addr, host_wdata, host_gnt, host_rdata, host_rvalid: same directions, widths and meanings as the core_* ports, for the matrix preload host.
REQ-014 host_lock  input  1  host burst hint: host keeps priority while it is high.
REQ-015 mem_en  output  1  memory access strobe.
REQ-016 mem_we  output  1  memory write enable.
REQ-017 mem_addr  output  AW  memory address.
REQ-018 mem_wdata  output  DW  memory write data.
REQ-019 mem_rdata  input  DW  memory read data, valid in the cycle after a mem_en read.
REQ-020 owner  output  1  owner of the current or last access: 0 core, 1 host.

Function
REQ-021 FSM states: IDLE, ISSUE, RDATA. Transitions: IDLE->ISSUE when any request is eligible; ISSUE->RDATA on a read; ISSUE->IDLE on a write; RDATA->IDLE always.
REQ-022 All outputs shall be registered; mem_en, mem_we, mem_addr, mem_wdata and the winner's gnt shall be driven only during ISSUE.
REQ-023 Timing: request sampled high in IDLE at cycle T -> gnt and mem_en at T+1 -> for reads, mem_rdata captured at the end of T+2 -> rvalid and rdata at T+3.
REQ-024 Throughput: one write per 2 cycles or one read per 3 cycles; a new arbitration may occur in the same cycle rvalid is high.
REQ-025 The requester granted in ISSUE shall be ignored at that edge, so a still-high req does not cause a duplicate access; a request re-sampled in IDLE is treated as new.
REQ-026 Arbitration uses round-robin on owner: if both request, the requester that did not own the last access wins.
REQ-027 Host lock: if host_lock=1, owner=1 and host_req=1, the host wins over core, subject to REQ-028.
REQ-028 A 4-bit starve counter increments on each host grant while core_req is high; it clears on any core grant or when core_req is low; at STARVE_MAX the core wins the next arbitration regardless of host_lock.
REQ-029 Read data shall be routed only to the requester that issued the read; the other rvalid stays 0.
REQ-030 mem_wdata shall be 0 for reads; mem_addr/mem_wdata shall hold their last values outside ISSUE with mem_en=0.
REQ-031 A request deasserted before grant is dropped silently with no gnt and no memory access.

Reset
REQ-032 Asserting rst shall immediately force state IDLE, all gnt/rvalid/mem_en/mem_we=0, mem_addr/mem_wdata/core_rdata/host_rdata=0, starve counter=0, and owner=1, so the core wins the first tie.
REQ-033 A read in flight when rst asserts shall be discarded, with no rvalid after reset release.
REQ-034 The first arbitration shall occur at the first rising edge after rst deasserts.

Verification
REQ-035 Core write at addr 0x010, data 0xA5, no host: core_gnt, mem_en and mem_we at T+1 with mem_addr=0x010 and mem_wdata=0xA5; FSM back in IDLE at T+2.
REQ-036 Core read at 0x010, memory returns 0xA5: core_rvalid=1 and core_rdata=0xA5 at T+3; host_rvalid stays 0.
REQ-037 Both request continuously after reset, host_lock=0: grants alternate core, host, core, host.
REQ-038 host_lock=1, host and core both requesting: 15 consecutive host grants, then a core grant, then the host resumes.
REQ-039 Host read issued, rst asserted during RDATA: outputs 0 immediately, no host_rvalid ever; after release a pending core_req is granted first.
REQ-040 core_req pulsed for 1 cycle while the host owns ISSUE: no core_gnt and no core memory access.

Source files
------------

// File: rtl/dram_arbiter.sv
// Two-requester (core / preload host) arbiter for a single-port data memory.
// Grant and strobe one cycle after sampling, read data two cycles later; requesters wait by holding req.
module dram_arbiter #(
    parameter int AW         = 12,
    parameter int DW         = 8,
    parameter int STARVE_MAX = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_gnt,
    output logic [DW-1:0] core_rdata,
    output logic          core_rvalid,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic [DW-1:0] host_rdata,
    output logic          host_rvalid,
    input  logic          host_lock,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          owner
);

    typedef enum logic [1:0] {IDLE, ISSUE, RDATA} state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic [3:0]    starve_q, starve_d;
    logic          core_gnt_q, core_gnt_d, host_gnt_q, host_gnt_d;
    logic          core_rvalid_q, core_rvalid_d, host_rvalid_q, host_rvalid_d;
    logic [DW-1:0] core_rdata_q, core_rdata_d, host_rdata_q, host_rdata_d;
    logic          mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          pick_host;

    // Starvation override beats the host lock, which beats plain round-robin.
    always_comb begin
        if (!core_req)
            pick_host = 1'b1;
        else if (!host_req)
            pick_host = 1'b0;
        else if (starve_q >= STARVE_LIM)
            pick_host = 1'b0;
        else if (host_lock && owner_q)
            pick_host = 1'b1;
        else
            pick_host = !owner_q;
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        starve_d      = starve_q;
        core_gnt_d    = 1'b0;
        host_gnt_d    = 1'b0;
        core_rvalid_d = 1'b0;
        host_rvalid_d = 1'b0;
        core_rdata_d  = core_rdata_q;
        host_rdata_d  = host_rdata_q;
        mem_en_d      = 1'b0;
        mem_we_d      = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (core_req || host_req) begin
                    state_d  = ISSUE;
                    mem_en_d = 1'b1;
                    if (pick_host) begin
                        host_gnt_d  = 1'b1;
                        owner_d     = 1'b1;
                        mem_we_d    = host_we;
                        mem_addr_d  = host_addr;
                        mem_wdata_d = host_we ? host_wdata : '0;
                    end else begin
                        core_gnt_d  = 1'b1;
                        owner_d     = 1'b0;
                        mem_we_d    = core_we;
                        mem_addr_d  = core_addr;
                        mem_wdata_d = core_we ? core_wdata : '0;
                    end
                end
            end
            ISSUE: state_d = mem_we_q ? IDLE : RDATA;
            RDATA: begin
                state_d = IDLE;
                if (owner_q) begin
                    host_rvalid_d = 1'b1;
                    host_rdata_d  = mem_rdata;
                end else begin
                    core_rvalid_d = 1'b1;
                    core_rdata_d  = mem_rdata;
                end
            end
            default: state_d = IDLE;
        endcase

        // Counts host wins the core had to sit through; any core win or idle core resets it.
        if (!core_req)
            starve_d = '0;
        else if (core_gnt_d)
            starve_d = '0;
        else if (host_gnt_d && starve_q != 4'hF)
            starve_d = starve_q + 4'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            owner_q       <= 1'b1;
            starve_q      <= '0;
            core_gnt_q    <= 1'b0;
            host_gnt_q    <= 1'b0;
            core_rvalid_q <= 1'b0;
            host_rvalid_q <= 1'b0;
            core_rdata_q  <= '0;
            host_rdata_q  <= '0;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            starve_q      <= starve_d;
            core_gnt_q    <= core_gnt_d;
            host_gnt_q    <= host_gnt_d;
            core_rvalid_q <= core_rvalid_d;
            host_rvalid_q <= host_rvalid_d;
            core_rdata_q  <= core_rdata_d;
            host_rdata_q  <= host_rdata_d;
            mem_en_q      <= mem_en_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
        end
    end

    assign core_gnt    = core_gnt_q;
    assign host_gnt    = host_gnt_q;
    assign core_rvalid = core_rvalid_q;
    assign host_rvalid = host_rvalid_q;
    assign core_rdata  = core_rdata_q;
    assign host_rdata  = host_rdata_q;
    assign mem_en      = mem_en_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign owner       = owner_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter: timing, round-robin, host lock with starvation, reset abort.
module tb_dram_arbiter;

    localparam int AW = 12;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          core_req = 1'b0, core_we = 1'b0;
    logic [AW-1:0] core_addr = '0;
    logic [DW-1:0] core_wdata = '0;
    logic          core_gnt, core_rvalid;
    logic [DW-1:0] core_rdata;
    logic          host_req = 1'b0, host_we = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic          host_gnt, host_rvalid;
    logic [DW-1:0] host_rdata;
    logic          host_lock = 1'b0;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          owner;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    dram_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(15)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rdata(core_rdata), .core_rvalid(core_rvalid),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .host_lock(host_lock),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .owner(owner)
    );

    always #5 clk = ~clk;

    // Synchronous single-port memory: read data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        total_cnt++;
        if ({core_gnt, host_gnt, core_rvalid, host_rvalid, mem_en, mem_we, owner} !== 7'b0000001) begin
            $display("FAIL reset_ctrl got %b want 0000001",
                     {core_gnt, host_gnt, core_rvalid, host_rvalid, mem_en, mem_we, owner});
        end else pass_cnt++;
        total_cnt++;
        if ({mem_addr, mem_wdata, core_rdata, host_rdata} !== '0) begin
            $display("FAIL reset_data got %h want 0", {mem_addr, mem_wdata, core_rdata, host_rdata});
        end else pass_cnt++;
    endtask

    task automatic test_core_write;
        core_req = 1'b1; core_we = 1'b1; core_addr = 12'h010; core_wdata = 8'hA5;
        tick;
        total_cnt++;
        if ({core_gnt, host_gnt, mem_en, mem_we, owner} !== 5'b10110) begin
            $display("FAIL wr_ctrl got %b want 10110", {core_gnt, host_gnt, mem_en, mem_we, owner});
        end else pass_cnt++;
        total_cnt++;
        if (mem_addr !== 12'h010 || mem_wdata !== 8'hA5) begin
            $display("FAIL wr_bus got %h/%h want 010/a5", mem_addr, mem_wdata);
        end else pass_cnt++;
        core_req = 1'b0;
        tick;
        total_cnt++;
        if (mem_en !== 1'b0 || core_gnt !== 1'b0 || mem_addr !== 12'h010 || mem_wdata !== 8'hA5) begin
            $display("FAIL wr_hold got en=%b gnt=%b %h/%h want 0 0 010/a5", mem_en, core_gnt, mem_addr, mem_wdata);
        end else pass_cnt++;
    endtask

    // Starts in the T+2 cycle of the write, which must already be IDLE.
    task automatic test_core_read;
        core_req = 1'b1; core_we = 1'b0; core_addr = 12'h010; core_wdata = 8'h77;
        tick;
        total_cnt++;
        if ({core_gnt, mem_en, mem_we} !== 3'b110 || mem_addr !== 12'h010 || mem_wdata !== 8'h00) begin
            $display("FAIL rd_issue got %b %h/%h want 110 010/00", {core_gnt, mem_en, mem_we}, mem_addr, mem_wdata);
        end else pass_cnt++;
        core_req = 1'b0;
        tick;
        total_cnt++;
        if ({core_rvalid, mem_en, core_gnt} !== 3'b000) begin
            $display("FAIL rd_wait got %b want 000", {core_rvalid, mem_en, core_gnt});
        end else pass_cnt++;
        tick;
        total_cnt++;
        if (core_rvalid !== 1'b1 || core_rdata !== 8'hA5 || host_rvalid !== 1'b0) begin
            $display("FAIL rd_data got v=%b d=%h hv=%b want 1 a5 0", core_rvalid, core_rdata, host_rvalid);
        end else pass_cnt++;
        tick;
        total_cnt++;
        if (core_rvalid !== 1'b0 || mem_en !== 1'b0) begin
            $display("FAIL rd_pulse got v=%b en=%b want 0 0", core_rvalid, mem_en);
        end else pass_cnt++;
    endtask

    task automatic test_round_robin;
        int q[$];
        int exp_seq[4];
        exp_seq = '{0, 1, 0, 1};
        core_req = 1'b1; core_we = 1'b1; core_addr = 12'h100; core_wdata = 8'h11;
        host_req = 1'b1; host_we = 1'b1; host_addr = 12'h200; host_wdata = 8'h22;
        host_lock = 1'b0;
        do_reset;
        for (int c = 0; c < 12; c++) begin
            tick;
            if (core_gnt) q.push_back(0);
            if (host_gnt) q.push_back(1);
        end
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (i >= q.size() || q[i] != exp_seq[i]) begin
                $display("FAIL rr_grant%0d got %0d want %0d (0 core,1 host,-1 none)",
                         i, (i < q.size()) ? q[i] : -1, exp_seq[i]);
            end else pass_cnt++;
        end
        core_req = 1'b0; host_req = 1'b0;
    endtask

    task automatic test_host_lock;
        int q[$];
        int want;
        core_req = 1'b1; core_we = 1'b1; core_addr = 12'h300; core_wdata = 8'h33;
        host_req = 1'b1; host_we = 1'b1; host_addr = 12'h400; host_wdata = 8'h44;
        host_lock = 1'b1;
        do_reset;
        for (int c = 0; c < 40; c++) begin
            tick;
            if (core_gnt) q.push_back(0);
            if (host_gnt) q.push_back(1);
        end
        for (int i = 0; i < 17; i++) begin
            want = (i == 15) ? 0 : 1;
            total_cnt++;
            if (i >= q.size() || q[i] != want) begin
                $display("FAIL lock_grant%0d got %0d want %0d (0 core,1 host,-1 none)",
                         i, (i < q.size()) ? q[i] : -1, want);
            end else pass_cnt++;
        end
        core_req = 1'b0; host_req = 1'b0; host_lock = 1'b0;
    endtask

    task automatic test_reset_during_read;
        logic saw_rv;
        saw_rv = 1'b0;
        do_reset;
        host_req = 1'b1; host_we = 1'b0; host_addr = 12'h020;
        tick;
        total_cnt++;
        if (host_gnt !== 1'b1 || mem_addr !== 12'h020 || owner !== 1'b1) begin
            $display("FAIL rdrst_issue got gnt=%b addr=%h own=%b want 1 020 1", host_gnt, mem_addr, owner);
        end else pass_cnt++;
        host_req = 1'b0;
        core_req = 1'b1; core_we = 1'b1; core_addr = 12'h055; core_wdata = 8'h5A;
        tick;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({core_gnt, host_gnt, core_rvalid, host_rvalid, mem_en, mem_we, owner} !== 7'b0000001 ||
            {mem_addr, mem_wdata, core_rdata, host_rdata} !== '0) begin
            $display("FAIL rdrst_async got %b %h want 0000001 0",
                     {core_gnt, host_gnt, core_rvalid, host_rvalid, mem_en, mem_we, owner},
                     {mem_addr, mem_wdata, core_rdata, host_rdata});
        end else pass_cnt++;
        for (int c = 0; c < 2; c++) begin
            tick;
            if (host_rvalid) saw_rv = 1'b1;
        end
        rst = 1'b0;
        tick;
        if (host_rvalid) saw_rv = 1'b1;
        total_cnt++;
        if (core_gnt !== 1'b1 || host_gnt !== 1'b0 || mem_addr !== 12'h055) begin
            $display("FAIL rdrst_first got cg=%b hg=%b addr=%h want 1 0 055", core_gnt, host_gnt, mem_addr);
        end else pass_cnt++;
        core_req = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick;
            if (host_rvalid) saw_rv = 1'b1;
        end
        total_cnt++;
        if (saw_rv !== 1'b0) begin
            $display("FAIL rdrst_no_rvalid got %b want 0", saw_rv);
        end else pass_cnt++;
    endtask

    task automatic test_core_pulse;
        logic saw_gnt, saw_acc;
        saw_gnt = 1'b0; saw_acc = 1'b0;
        do_reset;
        host_req = 1'b1; host_we = 1'b1; host_addr = 12'h0AB; host_wdata = 8'h66;
        tick;
        total_cnt++;
        if (host_gnt !== 1'b1 || core_gnt !== 1'b0) begin
            $display("FAIL pulse_host got hg=%b cg=%b want 1 0", host_gnt, core_gnt);
        end else pass_cnt++;
        host_req = 1'b0;
        core_req = 1'b1; core_we = 1'b1; core_addr = 12'h0AA; core_wdata = 8'h99;
        tick;
        core_req = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (core_gnt) saw_gnt = 1'b1;
            if (mem_en) saw_acc = 1'b1;
            tick;
        end
        total_cnt++;
        if ({saw_gnt, saw_acc} !== 2'b00) begin
            $display("FAIL pulse_dropped got gnt/acc=%b want 00", {saw_gnt, saw_acc});
        end else pass_cnt++;
    endtask

    initial begin
        tick;
        test_reset;
        rst = 1'b0;
        test_core_write;
        test_core_read;
        test_round_robin;
        test_host_lock;
        test_reset_during_read;
        test_core_pulse;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
